// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative write-back cache controller:
// FSM state encoding, default geometry and address-field width helpers.
package cache_pkg;

    localparam int NSETS_DEF      = 256;
    localparam int LINE_WORDS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITE_BACK,
        ST_ALLOCATE,
        ST_REFILL
    } state_t;

    function automatic int calc_off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int calc_idx_w(input int nsets);
        return $clog2(nsets);
    endfunction

    function automatic int calc_tag_w(input int nsets, input int line_words);
        return 32 - calc_idx_w(nsets) - calc_off_w(line_words);
    endfunction

endpackage

// File: rtl/sa_cache_way_store.sv
// One cache way: tag and line storage with a registered read port (old data on
// same-cycle read/write), a full-line write and a single-word write.
module sa_cache_way_store
    import cache_pkg::*;
#(
    parameter  int NSETS      = NSETS_DEF,
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    localparam int IDX_W      = calc_idx_w(NSETS),
    localparam int TAG_W      = calc_tag_w(NSETS, LINE_WORDS),
    localparam int LINE_W     = 32 * LINE_WORDS,
    localparam int SEL_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              line_we,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [31:0]       wr_word
);

    logic [TAG_W-1:0]  tag_mem  [NSETS];
    logic [LINE_W-1:0] data_mem [NSETS];

    // Non-blocking updates make a colliding read return the pre-write contents.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_line <= data_mem[rd_idx];
        end
        if (line_we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end else if (word_we) begin
            data_mem[wr_idx][wr_sel*32 +: 32] <= wr_word;
        end
    end

endmodule

// File: rtl/sa_cache_controller.sv
// 2-way set-associative, write-back / write-allocate cache controller with a
// single outstanding CPU request and a line-wide memory interface.
module sa_cache_controller
    import cache_pkg::*;
#(
    parameter  int NSETS      = NSETS_DEF,
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    localparam int OFF_W      = calc_off_w(LINE_WORDS),
    localparam int IDX_W      = calc_idx_w(NSETS),
    localparam int TAG_W      = calc_tag_w(NSETS, LINE_WORDS),
    localparam int LINE_W     = 32 * LINE_WORDS,
    localparam int SEL_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid_i,
    output logic              cpu_req_ready_o,
    input  logic              cpu_req_rw_i,
    input  logic [31:0]       cpu_req_addr_i,
    input  logic [31:0]       cpu_req_data_i,
    input  logic [3:0]        cpu_req_be_i,
    output logic              cpu_rsp_valid_o,
    output logic [31:0]       cpu_rsp_data_o,
    output logic              mem_req_valid_o,
    output logic              mem_req_rw_o,
    output logic [31:0]       mem_req_addr_o,
    output logic [LINE_W-1:0] mem_req_data_o,
    input  logic              mem_rsp_valid_i,
    input  logic [LINE_W-1:0] mem_rsp_data_i
);

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

    state_t state;

    logic             req_rw;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [SEL_W-1:0] req_sel;
    logic [31:0]      req_data;
    logic [3:0]       req_be;

    logic [NSETS-1:0] valid0, valid1, dirty0, dirty1, lru;
    logic             victim_way;

    logic              accept;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  tag0, tag1;
    logic [LINE_W-1:0] line0, line1;
    logic              fill_done;
    logic              line_we0, line_we1, word_we0, word_we1;

    logic              hit0, hit1, hit;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word, merged;
    logic              victim_sel, victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic [LINE_W-1:0] victim_line;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_req_addr_i[1:0];

    assign accept = (state == ST_IDLE) && cpu_req_valid_i && cpu_req_ready_o;
    assign rd_en  = accept || (state == ST_REFILL);
    assign rd_idx = accept ? cpu_req_addr_i[OFF_W +: IDX_W] : req_idx;

    assign hit0     = valid0[req_idx] && (tag0 == req_tag);
    assign hit1     = valid1[req_idx] && (tag1 == req_tag);
    assign hit      = hit0 || hit1;
    assign hit_line = hit1 ? line1 : line0;
    assign hit_word = hit_line[req_sel*32 +: 32];
    assign merged   = merge_word(hit_word, req_data, req_be);

    // Fill an invalid way first (way0 preferred), otherwise replace the LRU way.
    assign victim_sel   = !valid0[req_idx] ? 1'b0 : (!valid1[req_idx] ? 1'b1 : lru[req_idx]);
    assign victim_dirty = victim_sel ? (valid1[req_idx] && dirty1[req_idx])
                                     : (valid0[req_idx] && dirty0[req_idx]);
    assign victim_tag   = victim_sel ? tag1 : tag0;
    assign victim_line  = victim_sel ? line1 : line0;

    assign fill_done = (state == ST_ALLOCATE) && mem_req_valid_o && mem_rsp_valid_i;
    assign line_we0  = fill_done && !victim_way;
    assign line_we1  = fill_done && victim_way;
    assign word_we0  = (state == ST_COMPARE) && req_rw && hit0;
    assign word_we1  = (state == ST_COMPARE) && req_rw && hit1 && !hit0;

    sa_cache_way_store #(.NSETS(NSETS), .LINE_WORDS(LINE_WORDS)) way0_store (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_tag  (tag0),
        .rd_line (line0),
        .line_we (line_we0),
        .word_we (word_we0),
        .wr_idx  (req_idx),
        .wr_tag  (req_tag),
        .wr_line (mem_rsp_data_i),
        .wr_sel  (req_sel),
        .wr_word (merged)
    );

    sa_cache_way_store #(.NSETS(NSETS), .LINE_WORDS(LINE_WORDS)) way1_store (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_tag  (tag1),
        .rd_line (line1),
        .line_we (line_we1),
        .word_we (word_we1),
        .wr_idx  (req_idx),
        .wr_tag  (req_tag),
        .wr_line (mem_rsp_data_i),
        .wr_sel  (req_sel),
        .wr_word (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            valid0          <= '0;
            valid1          <= '0;
            dirty0          <= '0;
            dirty1          <= '0;
            lru             <= '0;
            victim_way      <= 1'b0;
            cpu_req_ready_o <= 1'b0;
            cpu_rsp_valid_o <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req_rw_o    <= 1'b0;
        end else begin
            cpu_rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cpu_req_ready_o <= 1'b1;
                    if (accept) begin
                        cpu_req_ready_o <= 1'b0;
                        state           <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (hit) begin
                        cpu_rsp_valid_o <= 1'b1;
                        cpu_req_ready_o <= 1'b1;
                        lru[req_idx]    <= !hit1;
                        if (req_rw) begin
                            if (hit0) dirty0[req_idx] <= 1'b1;
                            else      dirty1[req_idx] <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        victim_way      <= victim_sel;
                        mem_req_valid_o <= 1'b1;
                        mem_req_rw_o    <= victim_dirty;
                        state           <= victim_dirty ? ST_WRITE_BACK : ST_ALLOCATE;
                    end
                end
                ST_WRITE_BACK: begin
                    if (mem_rsp_valid_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    // Coming from write-back the request is re-raised after one idle cycle.
                    if (!mem_req_valid_o) begin
                        mem_req_valid_o <= 1'b1;
                        mem_req_rw_o    <= 1'b0;
                    end else if (mem_rsp_valid_i) begin
                        mem_req_valid_o <= 1'b0;
                        if (victim_way) begin
                            valid1[req_idx] <= 1'b1;
                            dirty1[req_idx] <= 1'b0;
                        end else begin
                            valid0[req_idx] <= 1'b1;
                            dirty0[req_idx] <= 1'b0;
                        end
                        state <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    state <= ST_COMPARE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_rw   <= cpu_req_rw_i;
            req_tag  <= cpu_req_addr_i[31 -: TAG_W];
            req_idx  <= cpu_req_addr_i[OFF_W +: IDX_W];
            req_sel  <= cpu_req_addr_i[2 +: SEL_W];
            req_data <= cpu_req_data_i;
            req_be   <= cpu_req_be_i;
        end
        if (state == ST_COMPARE) begin
            if (hit) begin
                cpu_rsp_data_o <= req_rw ? merged : hit_word;
            end else if (victim_dirty) begin
                mem_req_addr_o <= {victim_tag, req_idx, {OFF_W{1'b0}}};
                mem_req_data_o <= victim_line;
            end else begin
                mem_req_addr_o <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
        end
        if ((state == ST_ALLOCATE) && !mem_req_valid_o) begin
            mem_req_addr_o <= {req_tag, req_idx, {OFF_W{1'b0}}};
        end
    end

endmodule

// File: doc/sa_cache_controller.md
SA_CACHE_CONTROLLER -- requirements
Module: sa_cache_controller

Interface
REQ-001 SHALL have parameter NSETS, default 256: number of sets; power of two, 16..1024.
REQ-002 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line; one of 2, 4 or 8.
REQ-003 SHALL derive OFF_W=log2(LINE_WORDS)+2, IDX_W=log2(NSETS), TAG_W=32-IDX_W-OFF_W and LINE_W=32*LINE_WORDS.
REQ-004 SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 sync reset; cpu_req_valid_i in 1 request; cpu_req_ready_o out 1 accept; cpu_req_rw_i in 1 (1=write); cpu_req_addr_i in 32 byte address; cpu_req_data_i in 32 write data; cpu_req_be_i in 4 byte enables.
REQ-006 SHALL have ports: cpu_rsp_valid_o out 1 one-cycle response pulse; cpu_rsp_data_o out 32 read word or merged write word.
REQ-007 SHALL have ports: mem_req_valid_o out 1; mem_req_rw_o out 1 (1=write-back); mem_req_addr_o out 32 line address; mem_req_data_o out LINE_W victim line; mem_rsp_valid_i in 1 completion; mem_rsp_data_i in LINE_W refill line.

Function
REQ-008 SHALL be 2-way set-associative and write-back/write-allocate, with address split tag=[31:32-TAG_W], index=[OFF_W+IDX_W-1:OFF_W], word=[OFF_W-1:2].
REQ-009 SHALL implement FSM states IDLE, COMPARE, WRITE_BACK, ALLOCATE and REFILL.
REQ-010 SHALL drive cpu_req_ready_o=1 only in IDLE, and on valid&&ready SHALL latch rw/addr/data/be, issue array read, and move to COMPARE.
REQ-011 SHALL treat cpu_req_valid_i as ignored when ready=0; there is no queueing.
REQ-012 SHALL define a hit in COMPARE as valid[way] && tag[way]==latched tag, and SHALL NOT allow both ways to hit.
REQ-013 SHALL, on a read hit, pulse cpu_rsp_valid_o with the selected word in the cycle after COMPARE (acceptance cycle 0 -> response cycle 2) and return to IDLE.
REQ-014 SHALL, on a write hit, merge cpu data into the word per be bit (be=0 leaves data unchanged), write the hit way, set dirty, and respond with the merged word at the same latency.
REQ-015 SHALL, on any hit, set lru[set] to the non-hit way.
REQ-016 SHALL select the miss victim as the first invalid way (way0 preferred); otherwise lru[set].
REQ-017 SHALL, when the victim is valid and dirty, enter WRITE_BACK: mem_req_valid_o=1, rw=1, addr={victim tag, index, OFF_W zeros}, data=victim line.
REQ-018 SHALL enter ALLOCATE from a clean miss, or from WRITE_BACK after mem_rsp_valid_i: mem_req_valid_o=1, rw=0, addr={latched tag, index, zeros}.
REQ-019 SHALL hold mem_req_* stable and asserted until mem_rsp_valid_i, with mem_req_valid_o deasserted for one cycle between write-back and allocate.
REQ-020 SHALL, on mem_rsp_valid_i in ALLOCATE, write mem_rsp_data_i to the victim way with tag=latched tag, valid=1, dirty=0, then go to REFILL.
REQ-021 SHALL use REFILL as a one-cycle state to re-read the arrays before returning to COMPARE, which then hits; no write-first bypass is permitted.
REQ-022 SHALL ignore mem_rsp_valid_i outside WRITE_BACK and ALLOCATE.
REQ-023 SHALL require tag/data arrays with synchronous 1-cycle read and, on same-cycle read and write, SHALL return old data.

Reset
REQ-024 SHALL, under rst, set state=IDLE, clear all valid, dirty and lru bits, and set cpu_rsp_valid_o=0, mem_req_valid_o=0, mem_req_rw_o=0 and cpu_req_ready_o=0 in the reset cycle.
REQ-025 SHALL, on rst mid-miss, deassert mem_req_valid_o in the next cycle and discard the pending request without a response.
REQ-026 SHALL NOT reset tag and data RAM contents.

Structure
REQ-027 SHALL place state encodings, parameter defaults and the derived-width functions in shared package cache_pkg.
REQ-028 SHALL instantiate one sub-module, sa_cache_way_store (tag+data RAM, sync read, line write and word-merge write), once per way; valid/dirty/lru SHALL be flops in the top.

Verification
REQ-029 SHALL cover read miss: after reset, read 0x0000_1010 -> mem read addr 0x0000_1010; return word0=0xDEADBEEF -> rsp 0xDEADBEEF; reread hits with rsp at cycle 2 and no mem_req.
REQ-030 SHALL cover write merge: with word0=0xAABBCCDD, write 0x0000_1010 data 0x11223344 be=0011 -> rsp 0xAABB3344; subsequent read returns 0xAABB3344.
REQ-031 SHALL cover LRU replacement: read 0x1000, read 0x2000, read 0x1000, read 0x3000 -> the 0x2000 way is evicted with no write-back; read 0x1000 still hits.
REQ-032 SHALL cover dirty eviction: write 0x1000, write 0x2000, read 0x1000, read 0x3000 -> mem write rw=1 addr 0x0000_2000 with the dirty line, then read 0x0000_3000.
REQ-033 SHALL cover backpressure: hold mem_rsp_valid_i low 10 cycles -> mem_req_* stable, cpu_req_ready_o=0, and a cpu request offered meanwhile gets no response.
REQ-034 SHALL cover reset mid-ALLOCATE: assert rst -> mem_req_valid_o=0 next cycle; a subsequent read of the same address misses.
